// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA UART host wrapper.
//   - operand/bus widths, UART register word addresses and status bit positions
//   - main FSM state and load-phase enums
//   - avm_req_t: one Avalon request as issued by the FSM to the poll master
package rsa_pkg;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned AVM_DW = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 5;

    localparam logic [ADDR_W-1:0] RX_ADDR   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] TX_ADDR   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(2);

    localparam int unsigned RX_OK_BIT = 7;
    localparam int unsigned TX_OK_BIT = 6;

    // 32 bytes per received operand, 31 bytes per transmitted result
    localparam logic [CNT_W-1:0] LAST_RX_CNT = CNT_W'(31);
    localparam logic [CNT_W-1:0] LAST_TX_CNT = CNT_W'(30);

    typedef enum logic [2:0] {
        S_QRX,
        S_RX,
        S_CALC,
        S_WAIT,
        S_QTX,
        S_TX
    } state_e;

    typedef enum logic [1:0] {
        KEY_N,
        KEY_D,
        DATA
    } phase_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] wdata;
    } avm_req_t;

    // MSB-first byte accumulation into an operand register
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r,
                                                   input logic [BYTE_W-1:0] b);
        return {r[DATA_W-BYTE_W-1:0], b};
    endfunction

endpackage

// File: rtl/rsa_uart_wrapper_if.sv
// Avalon-MM bus between the wrapper (master) and the UART register block (slave).
//   avm_address/avm_read/avm_write/avm_writedata : master -> slave
//   avm_readdata/avm_waitrequest                 : slave  -> master
interface rsa_uart_wrapper_if;
    import rsa_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [AVM_DW-1:0] avm_readdata;
    logic              avm_write;
    logic [AVM_DW-1:0] avm_writedata;
    logic              avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/avm_poll_master.sv
// Single-outstanding Avalon-MM master used by the wrapper FSM.
//   i_clk, i_rst_n : clock, async active-low reset
//   req_i, cmd_i   : request from FSM (sampled only while idle)
//   done_c         : transfer completes this cycle (waitrequest low)
//   rdata_c        : read byte, valid with done_c
//   avm            : Avalon master port, all outputs registered
module avm_poll_master
    import rsa_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              req_i,
    input  avm_req_t          cmd_i,
    output logic              done_c,
    output logic [BYTE_W-1:0] rdata_c,
    rsa_uart_wrapper_if.master avm
);

    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTE_W-1:0] wdata_q;
    logic              busy_c;
    logic              unused_rdata_hi;

    assign busy_c  = read_q | write_q;
    assign done_c  = busy_c & ~avm.avm_waitrequest;
    assign rdata_c = avm.avm_readdata[BYTE_W-1:0];
    assign unused_rdata_hi = ^avm.avm_readdata[AVM_DW-1:BYTE_W];

    // Request held until waitrequest drops; a new one is accepted only from idle,
    // which leaves at least one idle cycle between transfers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= STAT_ADDR;
            wdata_q <= '0;
        end else if (busy_c) begin
            if (!avm.avm_waitrequest) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
            end
        end else if (req_i) begin
            read_q  <= ~cmd_i.write;
            write_q <= cmd_i.write;
            addr_q  <= cmd_i.addr;
            wdata_q <= cmd_i.wdata;
        end
    end

    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_address   = addr_q;
    assign avm.avm_writedata = {{(AVM_DW-BYTE_W){1'b0}}, wdata_q};

endmodule

// File: rtl/rsa_uart_wrapper.sv
// Host-side initiator for the 256-bit RSA core: loads n, d, then ciphertext
// blocks from the UART, runs the core per block and streams each result back.
//   i_clk, i_rst_n   : clock, async active-low reset
//   avm              : Avalon-MM master polling the UART registers
//   o_core_start     : one-cycle core start pulse
//   o_core_n/d/a     : modulus, exponent, ciphertext block
//   i_core_result    : a^d mod n, valid with i_core_finished
//   i_core_finished  : core done pulse
module rsa_uart_wrapper
    import rsa_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    rsa_uart_wrapper_if.master avm,
    output logic              o_core_start,
    output logic [DATA_W-1:0] o_core_n,
    output logic [DATA_W-1:0] o_core_d,
    output logic [DATA_W-1:0] o_core_a,
    input  logic [DATA_W-1:0] i_core_result,
    input  logic              i_core_finished
);

    state_e                   state_q;
    phase_e                   phase_q;
    logic [CNT_W-1:0]         byte_cnt_q;
    logic [DATA_W-1:0]        n_q;
    logic [DATA_W-1:0]        d_q;
    logic [DATA_W-1:0]        a_q;
    // Result top byte is never transmitted, so it is not stored
    logic [DATA_W-BYTE_W-1:0] out_q;
    logic                     start_q;

    logic                     req_c;
    avm_req_t                 cmd_c;
    logic                     done_c;
    logic [BYTE_W-1:0]        rdata_c;
    logic                     unused_result_top;

    assign unused_result_top = ^i_core_result[DATA_W-1:DATA_W-BYTE_W];

    // Bus request implied by the current state
    always_comb begin
        req_c       = 1'b0;
        cmd_c       = '0;
        cmd_c.addr  = STAT_ADDR;
        cmd_c.wdata = out_q[DATA_W-BYTE_W-1 -: BYTE_W];
        case (state_q)
            S_QRX, S_QTX: req_c = 1'b1;
            S_RX: begin
                req_c      = 1'b1;
                cmd_c.addr = RX_ADDR;
            end
            S_TX: begin
                req_c       = 1'b1;
                cmd_c.write = 1'b1;
                cmd_c.addr  = TX_ADDR;
            end
            default: ;
        endcase
    end

    avm_poll_master u_avm (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req_i   (req_c),
        .cmd_i   (cmd_c),
        .done_c  (done_c),
        .rdata_c (rdata_c),
        .avm     (avm)
    );

    // Main sequencer: load keys once, then receive/compute/transmit per block
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_QRX;
            phase_q    <= KEY_N;
            byte_cnt_q <= '0;
            n_q        <= '0;
            d_q        <= '0;
            a_q        <= '0;
            out_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_QRX: begin
                    if (done_c && rdata_c[RX_OK_BIT]) state_q <= S_RX;
                end
                S_RX: begin
                    if (done_c) begin
                        case (phase_q)
                            KEY_N:   n_q <= shift_in(n_q, rdata_c);
                            KEY_D:   d_q <= shift_in(d_q, rdata_c);
                            default: a_q <= shift_in(a_q, rdata_c);
                        endcase
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        state_q    <= S_QRX;
                        if (byte_cnt_q == LAST_RX_CNT) begin
                            case (phase_q)
                                KEY_N:   phase_q <= KEY_D;
                                KEY_D:   phase_q <= DATA;
                                default: begin
                                    state_q <= S_CALC;
                                    start_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_CALC: state_q <= S_WAIT;
                S_WAIT: begin
                    if (i_core_finished) begin
                        out_q   <= i_core_result[DATA_W-BYTE_W-1:0];
                        state_q <= S_QTX;
                    end
                end
                S_QTX: begin
                    if (done_c && rdata_c[TX_OK_BIT]) state_q <= S_TX;
                end
                S_TX: begin
                    if (done_c) begin
                        out_q <= {out_q[DATA_W-2*BYTE_W-1:0], {BYTE_W{1'b0}}};
                        if (byte_cnt_q == LAST_TX_CNT) begin
                            byte_cnt_q <= '0;
                            state_q    <= S_QRX;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                            state_q    <= S_QTX;
                        end
                    end
                end
                default: state_q <= S_QRX;
            endcase
        end
    end

    assign o_core_start = start_q;
    assign o_core_n     = n_q;
    assign o_core_d     = d_q;
    assign o_core_a     = a_q;

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// Self-checking bench for rsa_uart_wrapper: reactive UART slave, RSA core model,
// and a byte-level reference of what must be loaded and sent back.
module tb_rsa_uart_wrapper;
    import rsa_pkg::*;

    localparam int LIM = 8000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         core_start;
    logic [255:0] core_n, core_d, core_a;
    logic [255:0] core_result;
    logic         core_finished;

    always #5 clk = ~clk;

    rsa_uart_wrapper_if bus();

    rsa_uart_wrapper dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .avm             (bus),
        .o_core_start    (core_start),
        .o_core_n        (core_n),
        .o_core_d        (core_d),
        .o_core_a        (core_a),
        .i_core_result   (core_result),
        .i_core_finished (core_finished)
    );

    int checks = 0;
    int errors = 0;

    // UART slave model state
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [4:0]  log_q[$];
    int          stat_zero_left = 0;
    bit          rand_mode = 0;
    int          wr_stall_once = 0;
    bit          in_xfer = 0;
    int          wait_left = 0;
    int          hold = 0;
    logic [4:0]  x_addr;
    logic [31:0] x_wd;
    logic        x_rd, x_wr;
    bit          x_once = 0;
    int          once_hold = 0;
    int          hold_viol = 0;
    int          wd_hi_viol = 0;
    int          rx_underflow = 0;

    // Core model state
    bit           stray_en = 0;
    bit           core_pending = 0;
    int           core_delay = 0;
    logic [255:0] result_next = '0;
    logic [255:0] cap_n, cap_d, cap_a;
    int           start_cnt = 0;
    int           start_run = 0;
    int           start_max = 0;
    int           a_viol = 0;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: result bytes 247:240 first, down to 7:0
    function automatic logic [7:0] exp_tx(input logic [255:0] res, input int k);
        return 8'(res >> (8 * (30 - k)));
    endfunction

    // UART register block: decides waitrequest and responds at negedge
    always @(negedge clk) begin
        logic [31:0] s;
        logic [31:0] rd;
        if (!rst_n) begin
            in_xfer = 0;
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdata = '0;
        end else if (bus.avm_read || bus.avm_write) begin
            if (!in_xfer) begin
                in_xfer = 1;
                hold    = 1;
                x_addr  = bus.avm_address;
                x_wd    = bus.avm_writedata;
                x_rd    = bus.avm_read;
                x_wr    = bus.avm_write;
                x_once  = 0;
                if (bus.avm_write && wr_stall_once > 0) begin
                    wait_left     = wr_stall_once;
                    wr_stall_once = 0;
                    x_once        = 1;
                end else begin
                    wait_left = rand_mode ? int'($urandom_range(0, 2)) : 0;
                end
            end else begin
                hold++;
                if (bus.avm_address !== x_addr || bus.avm_writedata !== x_wd ||
                    bus.avm_read !== x_rd || bus.avm_write !== x_wr) hold_viol++;
            end
            if (wait_left > 0) begin
                bus.avm_waitrequest = 1'b1;
                bus.avm_readdata    = $urandom;
                wait_left--;
            end else begin
                bus.avm_waitrequest = 1'b0;
                in_xfer = 0;
                if (x_once) once_hold = hold;
                log_q.push_back(x_addr);
                rd = $urandom;
                if (x_wr) begin
                    if (x_addr == 5'd1) tx_q.push_back(x_wd[7:0]);
                    if (x_wd[31:8] != 24'd0) wd_hi_viol++;
                end else if (x_addr == 5'd2) begin
                    s = rand_mode ? $urandom : 32'd0;
                    if (stat_zero_left > 0) begin
                        s = 32'd0;
                        stat_zero_left--;
                    end else begin
                        s[7] = (rx_q.size() > 0) && (!rand_mode || $urandom_range(0, 2) != 0);
                        s[6] = !rand_mode || $urandom_range(0, 3) != 0;
                    end
                    rd = s;
                end else if (x_addr == 5'd0) begin
                    if (rx_q.size() > 0) rd[7:0] = rx_q.pop_front();
                    else rx_underflow++;
                end
                bus.avm_readdata = rd;
            end
        end else begin
            bus.avm_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.avm_readdata    = $urandom;
        end
    end

    // RSA core model: random latency, result taken from result_next
    always @(negedge clk) begin
        if (!rst_n) begin
            core_pending  = 0;
            core_finished = 1'b0;
            core_result   = '0;
            start_run     = 0;
        end else begin
            core_finished = 1'b0;
            core_result   = rand256();
            if (core_start) begin
                start_run++;
                if (start_run > start_max) start_max = start_run;
                if (start_run == 1) begin
                    start_cnt++;
                    cap_n = core_n;
                    cap_d = core_d;
                    cap_a = core_a;
                    core_pending = 1;
                    core_delay = int'($urandom_range(1, 6));
                end
            end else begin
                start_run = 0;
                if (core_pending) begin
                    if (core_a !== cap_a) a_viol++;
                    if (core_delay == 0) begin
                        core_finished = 1'b1;
                        core_result   = result_next;
                        core_pending  = 0;
                    end else begin
                        core_delay--;
                    end
                end else if (stray_en && $urandom_range(0, 15) == 0) begin
                    core_finished = 1'b1;
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [255:0] v);
        for (int k = 0; k < 32; k++) rx_q.push_back(8'(v >> (8 * (31 - k))));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_q.delete();
        tx_q.delete();
        log_q.delete();
        stat_zero_left = 0;
        wr_stall_once  = 0;
        wait_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int s0, output bit timed_out);
        int n = 0;
        while (start_cnt == s0 && n < LIM) begin
            @(posedge clk);
            n++;
        end
        #1;
        timed_out = (start_cnt == s0);
    endtask

    task automatic wait_tx(input int cnt, output bit timed_out);
        int n = 0;
        while (tx_q.size() < cnt && n < LIM) begin
            @(posedge clk);
            n++;
        end
        timed_out = (tx_q.size() < cnt);
        wait_cycles(30);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.avm_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", bus.avm_read); end
        checks++; if (bus.avm_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", bus.avm_write); end
        checks++; if (bus.avm_address !== 5'd2) begin errors++; $display("FAIL reset_addr got %0d want 2", bus.avm_address); end
        checks++; if (bus.avm_writedata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.avm_writedata); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", core_start); end
        checks++; if ({core_n, core_d, core_a} !== 768'd0) begin errors++; $display("FAIL reset_core_regs got nonzero want 0"); end
        wait_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.avm_read !== 1'b1) begin errors++; $display("FAIL first_read got %b want 1", bus.avm_read); end
        checks++; if (bus.avm_address !== 5'd2) begin errors++; $display("FAIL first_addr got %0d want 2", bus.avm_address); end
    endtask

    task automatic test_status_poll();
        bit to;
        int n = 0;
        int bad = 0;
        log_q.delete();
        stat_zero_left = 10;
        push_word(256'd221);
        while (rx_q.size() > 0 && n < LIM) begin
            @(posedge clk);
            n++;
        end
        to = (rx_q.size() > 0);
        wait_cycles(4);
        checks++; if (to) begin errors++; $display("FAIL poll_timeout got %0d left want 0", rx_q.size()); end
        checks++; if (log_q.size() < 12) begin errors++; $display("FAIL poll_log_len got %0d want >=12", log_q.size()); end
        else begin
            for (int i = 0; i < 11; i++) if (log_q[i] !== 5'd2) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL poll_status_only got %0d non-status want 0", bad); end
            checks++; if (log_q[11] !== 5'd0) begin errors++; $display("FAIL poll_rx_after got addr %0d want 0", log_q[11]); end
        end
        checks++; if (core_n !== 256'd221) begin errors++; $display("FAIL key_n got %0d want 221", core_n); end
    endtask

    task automatic test_key_block();
        bit to;
        int s0 = start_cnt;
        logic [255:0] res;
        res[255:248] = 8'hFF;
        for (int k = 0; k < 31; k++) res[247 - 8*k -: 8] = 8'(30 - k);
        result_next = res;
        start_max = 0;
        tx_q.delete();
        push_word(256'd20);
        push_word(256'd5);
        wait_start(s0, to);
        checks++; if (to) begin errors++; $display("FAIL key_start_timeout got none want 1"); end
        checks++; if (cap_n !== 256'd221) begin errors++; $display("FAIL core_n got %0d want 221", cap_n); end
        checks++; if (cap_d !== 256'd20) begin errors++; $display("FAIL core_d got %0d want 20", cap_d); end
        checks++; if (cap_a !== 256'd5) begin errors++; $display("FAIL core_a got %0d want 5", cap_a); end
        wait_tx(31, to);
        checks++; if (tx_q.size() != 31) begin errors++; $display("FAIL tx_count got %0d want 31", tx_q.size()); end
        else begin
            for (int k = 0; k < 31; k++) begin
                checks++; if (tx_q[k] !== exp_tx(res, k)) begin errors++; $display("FAIL tx_byte%0d got %h want %h", k, tx_q[k], exp_tx(res, k)); end
            end
        end
        checks++; if (start_max != 1) begin errors++; $display("FAIL start_width got %0d want 1", start_max); end
        checks++; if (start_cnt != s0 + 1) begin errors++; $display("FAIL start_count got %0d want %0d", start_cnt, s0 + 1); end
        checks++; if (wd_hi_viol != 0) begin errors++; $display("FAIL wdata_upper got %0d want 0", wd_hi_viol); end
        checks++; if (log_q[$] !== 5'd2) begin errors++; $display("FAIL back_to_qrx got addr %0d want 2", log_q[$]); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int s0 = start_cnt;
        int rx_reads = 0;
        logic [255:0] res = rand256();
        result_next = res;
        log_q.delete();
        tx_q.delete();
        hold_viol = 0;
        once_hold = 0;
        wr_stall_once = 3;
        push_word(256'd7);
        wait_start(s0, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_start_timeout got none want 1"); end
        checks++; if (cap_a !== 256'd7) begin errors++; $display("FAIL b2b_a got %0d want 7", cap_a); end
        checks++; if (cap_n !== 256'd221 || cap_d !== 256'd20) begin errors++; $display("FAIL b2b_keys got n=%0d d=%0d want 221/20", cap_n, cap_d); end
        wait_tx(31, to);
        foreach (log_q[i]) if (log_q[i] == 5'd0) rx_reads++;
        checks++; if (rx_reads != 32) begin errors++; $display("FAIL b2b_rx_reads got %0d want 32", rx_reads); end
        checks++; if (once_hold != 4) begin errors++; $display("FAIL wait_hold got %0d want 4", once_hold); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL hold_stable got %0d want 0", hold_viol); end
        checks++; if (tx_q.size() != 31) begin errors++; $display("FAIL b2b_tx_count got %0d want 31", tx_q.size()); end
        else begin
            for (int k = 0; k < 31; k++) begin
                checks++; if (tx_q[k] !== exp_tx(res, k)) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", k, tx_q[k], exp_tx(res, k)); end
            end
        end
    endtask

    task automatic test_random_blocks();
        bit to;
        rand_mode = 1;
        stray_en  = 1;
        for (int b = 0; b < 3; b++) begin
            int s0 = start_cnt;
            logic [255:0] a = rand256();
            logic [255:0] res = rand256();
            result_next = res;
            tx_q.delete();
            push_word(a);
            wait_start(s0, to);
            checks++; if (cap_a !== a) begin errors++; $display("FAIL rnd%0d_a got %h want %h", b, cap_a, a); end
            wait_tx(31, to);
            checks++; if (tx_q.size() != 31) begin errors++; $display("FAIL rnd%0d_tx_count got %0d want 31", b, tx_q.size()); end
            else begin
                for (int k = 0; k < 31; k++) begin
                    checks++; if (tx_q[k] !== exp_tx(res, k)) begin errors++; $display("FAIL rnd%0d_byte%0d got %h want %h", b, k, tx_q[k], exp_tx(res, k)); end
                end
            end
        end
        checks++; if (a_viol != 0) begin errors++; $display("FAIL a_stable got %0d want 0", a_viol); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL rnd_hold got %0d want 0", hold_viol); end
        checks++; if (rx_underflow != 0) begin errors++; $display("FAIL rx_underflow got %0d want 0", rx_underflow); end
    endtask

    task automatic test_reset_midstream();
        bit to;
        int n = 0;
        int s0;
        logic [255:0] kn = rand256();
        logic [255:0] kd = rand256();
        logic [255:0] a  = rand256();
        logic [255:0] res = rand256();
        apply_reset();
        for (int k = 0; k < 10; k++) rx_q.push_back(8'($urandom));
        while (rx_q.size() > 0 && n < LIM) begin
            @(posedge clk);
            n++;
        end
        wait_cycles(3);
        apply_reset();
        checks++; if (core_n !== 256'd0) begin errors++; $display("FAIL midrst_n_cleared got %h want 0", core_n); end
        s0 = start_cnt;
        result_next = res;
        push_word(kn);
        push_word(kd);
        push_word(a);
        wait_start(s0, to);
        checks++; if (to) begin errors++; $display("FAIL midrst_start_timeout got none want 1"); end
        checks++; if (cap_n !== kn) begin errors++; $display("FAIL midrst_n got %h want %h", cap_n, kn); end
        checks++; if (cap_d !== kd) begin errors++; $display("FAIL midrst_d got %h want %h", cap_d, kd); end
        checks++; if (cap_a !== a) begin errors++; $display("FAIL midrst_a got %h want %h", cap_a, a); end
        wait_tx(31, to);
        checks++; if (tx_q.size() != 31) begin errors++; $display("FAIL midrst_tx_count got %0d want 31", tx_q.size()); end
        else begin
            for (int k = 0; k < 31; k++) begin
                checks++; if (tx_q[k] !== exp_tx(res, k)) begin errors++; $display("FAIL midrst_byte%0d got %h want %h", k, tx_q[k], exp_tx(res, k)); end
            end
        end
    endtask

    initial begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = '0;
        core_finished       = 1'b0;
        core_result         = '0;
        test_reset();
        test_status_poll();
        test_key_block();
        test_back_to_back();
        test_random_blocks();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
